// File: rtl/memory_s_dp_param_be.sv
// ---------------------------------------------------------------------------
// memory_s_dp_param_be
//
// Simple dual-port synchronous SRAM model used as on-chip RAM in emulation
// builds. It has one write port and one read port on a shared clock. It
// supports per-byte write enables and a read latency of 1 or 2. The
// read-during-write result is selectable. A clear engine zeroes the whole
// array after reset or on request.
//
// Ports
//   sram_clock              clock, rising edge
//   int_reset               asynchronous active-low reset
//   sram_read               read request
//   sram_read_address       read address
//   sram_read_data          read data, 0 when sram_read_valid is low
//   sram_read_valid         sram_read_data holds a completed read
//   sram_write              write request
//   sram_write_address      write address
//   sram_write_data         write data
//   sram_write_byte_enables one enable per BYTE_WIDTH lane
//   sram_init               pulse to start a clear sweep
//   sram_busy               clear sweep running; new reads/writes ignored
// ---------------------------------------------------------------------------
module memory_s_dp_param_be #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             sram_clock,
  input  logic                             int_reset,
  input  logic                             sram_read,
  input  logic [ADDR_WIDTH-1:0]            sram_read_address,
  output logic [DATA_WIDTH-1:0]            sram_read_data,
  output logic                             sram_read_valid,
  input  logic                             sram_write,
  input  logic [ADDR_WIDTH-1:0]            sram_write_address,
  input  logic [DATA_WIDTH-1:0]            sram_write_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] sram_write_byte_enables,
  input  logic                             sram_init,
  output logic                             sram_busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam bit RDW_NEW = (RDW_MODE != 0);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_CLEARING : ST_IDLE;

  // -------------------------------------------------------------------------
  // Clear FSM
  // -------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;

  always_ff @(posedge sram_clock or negedge int_reset) begin
    if (!int_reset) begin
      state_q <= RESET_STATE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sram_init) begin
          state_d = ST_CLEARING;
          count_d = '0;
        end
      end
      ST_CLEARING: begin
        // The last word is zeroed on the same edge that returns to IDLE,
        // so the sweep takes exactly DEPTH cycles.
        if (count_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign sram_busy = (state_q == ST_CLEARING);

  // -------------------------------------------------------------------------
  // Request qualification
  // -------------------------------------------------------------------------
  logic wr_qual;
  logic rd_qual;

  assign wr_qual = sram_write && !sram_busy;
  assign rd_qual = sram_read  && !sram_busy;

  // -------------------------------------------------------------------------
  // Memory array with a single write port shared by user writes and the
  // clear engine. User writes are blocked while clearing, so the two never
  // compete.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NB-1:0]         mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = '0;
    mem_waddr = sram_write_address;
    mem_wdata = sram_write_data;
    if (sram_busy) begin
      mem_we    = '1;
      mem_waddr = count_q;
      mem_wdata = '0;
    end else if (wr_qual) begin
      mem_we    = sram_write_byte_enables;
    end
  end

  always_ff @(posedge sram_clock) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) begin
        mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path. The array read returns the pre-write word. In new-data mode
  // the enabled lanes of a same-address write are forwarded over it.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_hit;

  assign rd_old = mem[sram_read_address];
  assign rd_hit = RDW_NEW && wr_qual && (sram_write_address == sram_read_address);

  for (genvar gi = 0; gi < NB; gi++) begin : g_rdw_lane
    assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      (rd_hit && sram_write_byte_enables[gi]) ? sram_write_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                              : rd_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // First output stage. Data is forced to 0 when no read was accepted, so
  // an idle cycle never shows stale data.
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic                  valid1_q, valid1_d;

  always_comb begin
    valid1_d = rd_qual;
    data1_d  = rd_qual ? rd_word : '0;
  end

  always_ff @(posedge sram_clock or negedge int_reset) begin
    if (!int_reset) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      data1_q  <= data1_d;
      valid1_q <= valid1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] data2_q;
    logic                  valid2_q;

    always_ff @(posedge sram_clock or negedge int_reset) begin
      if (!int_reset) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        data2_q  <= data1_q;
        valid2_q <= valid1_q;
      end
    end

    assign sram_read_data  = data2_q;
    assign sram_read_valid = valid2_q;
  end else begin : g_lat1
    assign sram_read_data  = data1_q;
    assign sram_read_valid = valid1_q;
  end

endmodule

// File: tb/tb_memory_s_dp_param_be.sv
// ---------------------------------------------------------------------------
// Bench for memory_s_dp_param_be. Two instances share every input:
//   dut_a: READ_LATENCY=1, RDW_MODE=0 (old data)
//   dut_b: READ_LATENCY=2, RDW_MODE=1 (merged new data)
// The scoreboard pushes one expected output record per cycle and per DUT.
// dut_b's queue holds one extra reset-value entry, which accounts for its
// additional cycle of latency.
// ---------------------------------------------------------------------------
module tb_memory_s_dp_param_be;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd, wr, init;
  logic [AW-1:0] ra, wa;
  logic [DW-1:0] wd;
  logic [NB-1:0] be;

  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  memory_s_dp_param_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dut_a (
    .sram_clock(clk), .int_reset(rst_n),
    .sram_read(rd), .sram_read_address(ra),
    .sram_read_data(rdata_a), .sram_read_valid(rvalid_a),
    .sram_write(wr), .sram_write_address(wa), .sram_write_data(wd),
    .sram_write_byte_enables(be), .sram_init(init), .sram_busy(busy_a)
  );

  memory_s_dp_param_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) dut_b (
    .sram_clock(clk), .int_reset(rst_n),
    .sram_read(rd), .sram_read_address(ra),
    .sram_read_data(rdata_b), .sram_read_valid(rvalid_b),
    .sram_write(wr), .sram_write_address(wa), .sram_write_data(wd),
    .sram_write_byte_enables(be), .sram_init(init), .sram_busy(busy_b)
  );

  typedef struct {
    logic          rd;
    logic [AW-1:0] ra;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic          init;
    logic          chk;    // use the hand-written expectations below
    logic [DW-1:0] exp_a;  // old-data result
    logic [DW-1:0] exp_b;  // merged new-data result
  } vec_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] mmem [DEPTH];
  logic          m_busy;
  logic [AW-1:0] m_cnt;
  int            checks = 0;
  int            passes = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic vec_t mk(logic r, logic [AW-1:0] rad, logic w, logic [AW-1:0] wad,
                              logic [DW-1:0] wdat, logic [NB-1:0] ben, logic in,
                              logic c, logic [DW-1:0] ea, logic [DW-1:0] eb);
    vec_t v;
    v.rd = r; v.ra = rad; v.wr = w; v.wa = wad; v.wd = wdat; v.be = ben;
    v.init = in; v.chk = c; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rd_chk(logic [AW-1:0] a, logic [DW-1:0] e);
    return mk(1, a, 0, 0, 0, 0, 0, 1, e, e);
  endfunction

  task automatic model_reset();
    exp_t z;
    z.v = 1'b0; z.d = '0;
    q_a.delete();
    q_b.delete();
    q_b.push_back(z);
    m_busy = 1'b1;
    m_cnt  = '0;
  endtask

  // Drive one cycle, predict the outputs, clock, then check.
  task automatic step(input vec_t v, input string tag);
    exp_t          ea, eb, ga, gb;
    logic          q;
    logic [DW-1:0] old, mrg;
    rd = v.rd; ra = v.ra; wr = v.wr; wa = v.wa; wd = v.wd; be = v.be; init = v.init;
    q   = v.rd && !m_busy;
    old = mmem[v.ra];
    mrg = old;
    if (v.wr && !m_busy && v.wa == v.ra)
      for (int i = 0; i < NB; i++) if (v.be[i]) mrg[i*8 +: 8] = v.wd[i*8 +: 8];
    ea.v = q; ea.d = q ? (v.chk ? v.exp_a : old) : '0;
    eb.v = q; eb.d = q ? (v.chk ? v.exp_b : mrg) : '0;
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    if (m_busy) begin
      mmem[m_cnt] = '0;
      if (m_cnt == AW'(DEPTH - 1)) m_busy = 1'b0;
      else m_cnt = m_cnt + AW'(1);
    end else begin
      if (v.wr)
        for (int i = 0; i < NB; i++) if (v.be[i]) mmem[v.wa][i*8 +: 8] = v.wd[i*8 +: 8];
      if (v.init) begin
        m_busy = 1'b1;
        m_cnt  = '0;
      end
    end
    #1;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      chk({tag, " queue_empty"}, 32'd1, 32'd0);
    end else begin
      ga = q_a.pop_front();
      gb = q_b.pop_front();
      $display("[%0t] %s rd=%0d ra=%h wr=%0d wa=%h wd=%h be=%b init=%0d | a:%0d/%h b:%0d/%h busy=%0d",
               $time, tag, v.rd, v.ra, v.wr, v.wa, v.wd, v.be, v.init,
               rvalid_a, rdata_a, rvalid_b, rdata_b, busy_a);
      chk({tag, " valid_a"}, {31'd0, rvalid_a}, {31'd0, ga.v});
      chk({tag, " data_a"},  rdata_a, ga.d);
      chk({tag, " valid_b"}, {31'd0, rvalid_b}, {31'd0, gb.v});
      chk({tag, " data_b"},  rdata_b, gb.d);
    end
    chk({tag, " busy_a"}, {31'd0, busy_a}, {31'd0, m_busy});
    chk({tag, " busy_b"}, {31'd0, busy_b}, {31'd0, m_busy});
  endtask

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst_valid_a"}, {31'd0, rvalid_a}, 32'd0);
    chk({tag, " rst_data_a"},  rdata_a, 32'd0);
    chk({tag, " rst_valid_b"}, {31'd0, rvalid_b}, 32'd0);
    chk({tag, " rst_data_b"},  rdata_b, 32'd0);
    chk({tag, " rst_busy"},    {31'd0, busy_a}, 32'd1);
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  // Count cycles until busy drops, with a bound so a stuck FSM cannot hang.
  task automatic count_busy(input int start, input string tag);
    int n;
    n = start;
    while (busy_a && n < 100) begin
      step(idle(), tag);
      n++;
    end
    chk({tag, " sweep_len"}, n, DEPTH);
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; rd = 0; wr = 0; init = 0; ra = '0; wa = '0; wd = '0; be = '0;
    tbl.push_back(mk(0, 0,    1, 4'h5, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    1, 4'h5, 32'h11223344, 4'b0101, 0, 0, 0, 0));
    tbl.push_back(rd_chk(4'h5, 32'hDE22BE44));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(rd_chk(4'h5, 32'hDE22BE44));
    tbl.push_back(mk(0, 0,    1, 4'hA, 32'hAAAAAAAA, 4'b1111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 1, 4'hA, 32'h55555555, 4'b1111, 0, 1, 32'hAAAAAAAA, 32'h55555555));
    tbl.push_back(mk(1, 4'hA, 1, 4'hA, 32'h12345678, 4'b0011, 0, 1, 32'h55555555, 32'h55555678));
    tbl.push_back(rd_chk(4'hA, 32'h55555678));
    tbl.push_back(mk(1, 4'h5, 1, 4'h7, 32'hCAFEF00D, 4'b1111, 0, 1, 32'hDE22BE44, 32'hDE22BE44));
    tbl.push_back(mk(1, 4'h7, 1, 4'h5, 32'hFFFFFFFF, 4'b0000, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D));
    tbl.push_back(rd_chk(4'h5, 32'hDE22BE44));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(rd_chk(4'h7, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(rd_chk(4'hA, 32'h55555678));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0));

    // Reset state, then the initial sweep after release.
    #22;
    chk("reset valid_a", {31'd0, rvalid_a}, 32'd0);
    chk("reset data_b",  rdata_b, 32'd0);
    chk("reset busy_a",  {31'd0, busy_a}, 32'd1);
    model_reset();
    #5;
    rst_n = 1'b1;
    count_busy(0, "init_sweep");

    // Every location reads back zero after the sweep.
    for (int i = 0; i < DEPTH; i++) step(rd_chk(AW'(i), 32'h0), "read_zero");

    // Byte enables, read-during-write, idle result cycles.
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // init together with a read and a write: both complete on that edge.
    step(mk(1, 4'h5, 1, 4'h9, 32'h00000077, 4'b1111, 1, 1, 32'hDE22BE44, 32'hDE22BE44), "init_pulse");
    // Requests during the sweep are dropped.
    step(mk(1, 4'h3, 1, 4'h3, 32'h12345678, 4'b1111, 1, 0, 0, 0), "busy_req");
    count_busy(1, "req_sweep");
    step(rd_chk(4'h3, 32'h0), "after_sweep3");
    step(rd_chk(4'h9, 32'h0), "after_sweep9");
    step(idle(), "drain");

    // Reset while a read result is on the outputs.
    tbl.delete();
    step(mk(0, 0, 1, 4'h5, 32'h0BADF00D, 4'b1111, 0, 0, 0, 0), "pre_wr");
    step(rd_chk(4'h5, 32'h0BADF00D), "pre_rd");
    async_reset("idle_rst");
    for (int i = 0; i < 5; i++) step(idle(), "mid_sweep");
    // Reset halfway through a sweep restarts it from address 0.
    async_reset("sweep_rst");
    count_busy(0, "restart_sweep");
    step(rd_chk(4'h5, 32'h0), "post_restart");
    step(idle(), "drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
